// File: rtl/exe_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// Flag bit positions and ALU opcodes are common to arbiter and ALU.
package exe_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int FLAG_SF = 0;
  localparam int FLAG_OF = 1;
  localparam int FLAG_NF = 2;
  localparam int FLAG_BF = 3;

  localparam int ARB_M    = 8;
  localparam int ARB_OP_W = 4;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;
  localparam int OP_SHL = 5;
  localparam int OP_SHR = 6;

endpackage

// File: rtl/exe_unit_arbiter_rr_picker.sv
// Round-robin winner select: first set request after ptr, wrapping.
// Purely combinational in req and ptr.
module rr_picker #(
  parameter  int N_REQ = 4,
  localparam int W     = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [W-1:0]     idx,
  output logic             any
);

  int d;
  int best;

  // distance from ptr+1; smallest distance wins
  always_comb begin
    d    = 0;
    best = N_REQ;
    idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      d = (k + 2 * N_REQ - 1 - int'(ptr)) % N_REQ;
      if (req[k] && d < best) begin
        best = d;
        idx  = W'(k);
      end
    end
    any = |req;
    gnt = any ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/exe_unit_rtl.sv
// Combinational ALU shared by all requesters.
// SF = sign, OF = signed overflow, NF = null result, BF = carry/borrow.
module exe_unit_rtl
  import exe_arb_pkg::*;
#(
  parameter int M    = ARB_M,
  parameter int OP_W = ARB_OP_W
) (
  input  logic [M-1:0]    arg_a,
  input  logic [M-1:0]    arg_b,
  input  logic [OP_W-1:0] oper,
  output logic [M-1:0]    result,
  output logic [3:0]      flags
);

  logic [M:0] wide;
  logic       carry;
  logic       ovf;

  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    flags  = '0;
    case (oper)
      OP_W'(OP_ADD): begin
        wide   = {1'b0, arg_a} + {1'b0, arg_b};
        result = wide[M-1:0];
        carry  = wide[M];
        ovf    = (arg_a[M-1] == arg_b[M-1]) &&
                 (result[M-1] != arg_a[M-1]);
      end
      OP_W'(OP_SUB): begin
        wide   = {1'b0, arg_a} - {1'b0, arg_b};
        result = wide[M-1:0];
        carry  = wide[M];
        ovf    = (arg_a[M-1] != arg_b[M-1]) &&
                 (result[M-1] != arg_a[M-1]);
      end
      OP_W'(OP_AND): result = arg_a & arg_b;
      OP_W'(OP_OR):  result = arg_a | arg_b;
      OP_W'(OP_XOR): result = arg_a ^ arg_b;
      OP_W'(OP_SHL): begin
        result = {arg_a[M-2:0], 1'b0};
        carry  = arg_a[M-1];
      end
      OP_W'(OP_SHR): begin
        result = {1'b0, arg_a[M-1:1]};
        carry  = arg_a[0];
      end
      default: result = arg_a;
    endcase
    flags[FLAG_SF] = result[M-1];
    flags[FLAG_OF] = ovf;
    flags[FLAG_NF] = (result == '0);
    flags[FLAG_BF] = carry;
  end

endmodule

// File: rtl/exe_unit_arbiter.sv
// Round-robin front end sharing one exe_unit_rtl ALU among N_REQ
// requesters; one operation in flight, results on valid/ack.
module exe_unit_arbiter
  import exe_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int M       = ARB_M,
  parameter int OP_W    = ARB_OP_W,
  parameter int TIMEOUT = 15
) (
  input  logic                  i_clk_p,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*M-1:0]    i_argA,
  input  logic [N_REQ*M-1:0]    i_argB,
  input  logic [N_REQ*OP_W-1:0] i_oper,
  input  logic [N_REQ-1:0]      i_ack,
  output logic [N_REQ-1:0]      o_gnt,
  output logic [N_REQ-1:0]      o_valid,
  output logic [M-1:0]          o_result,
  output logic [3:0]            o_flags,
  output logic                  o_busy,
  output logic                  o_timeout
);

  localparam int W = $clog2(N_REQ);

  state_e          state;
  logic [W-1:0]    ptr;
  logic [W-1:0]    win;
  logic [M-1:0]    cap_a;
  logic [M-1:0]    cap_b;
  logic [OP_W-1:0] cap_op;
  logic [7:0]      cnt;

  logic [N_REQ-1:0] pick_gnt;
  logic [W-1:0]     pick_idx;
  logic             pick_any;
  logic [M-1:0]     alu_res;
  logic [3:0]       alu_flags;

  logic [M-1:0]    lane_a  [N_REQ];
  logic [M-1:0]    lane_b  [N_REQ];
  logic [OP_W-1:0] lane_op [N_REQ];

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      lane_a[k]  = i_argA[k*M +: M];
      lane_b[k]  = i_argB[k*M +: M];
      lane_op[k] = i_oper[k*OP_W +: OP_W];
    end
  end

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req (i_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // ALU only ever sees the captured operands
  exe_unit_rtl #(.M(M), .OP_W(OP_W)) u_alu (
    .arg_a  (cap_a),
    .arg_b  (cap_b),
    .oper   (cap_op),
    .result (alu_res),
    .flags  (alu_flags)
  );

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk_p) begin
    if (i_rst) begin
      state     <= IDLE;
      ptr       <= W'(N_REQ - 1);
      win       <= '0;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_op    <= '0;
      cnt       <= '0;
      o_gnt     <= '0;
      o_valid   <= '0;
      o_result  <= '0;
      o_flags   <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_gnt     <= '0;
      o_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            cap_a  <= lane_a[pick_idx];
            cap_b  <= lane_b[pick_idx];
            cap_op <= lane_op[pick_idx];
            win    <= pick_idx;
            o_gnt  <= pick_gnt;
            state  <= EXEC;
          end
        end
        EXEC: begin
          o_result <= alu_res;
          o_flags  <= alu_flags;
          o_valid  <= N_REQ'(1) << win;
          cnt      <= '0;
          state    <= RESP;
        end
        RESP: begin
          // ack on the expiry cycle takes precedence over abort
          if (i_ack[win]) begin
            o_valid <= '0;
            ptr     <= win;
            state   <= IDLE;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            o_valid   <= '0;
            o_timeout <= 1'b1;
            ptr       <= win;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_unit_arbiter.sv
// Bench for exe_unit_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction model.
module tb_exe_unit_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] argA = '0;
  logic [31:0] argB = '0;
  logic [15:0] oper = '0;
  logic [3:0]  ack = '0;
  logic [3:0]  o_gnt, o_valid, o_flags;
  logic [7:0]  o_result;
  logic        o_busy, o_timeout;

  int checks = 0;
  int errors = 0;

  exe_unit_arbiter #(.N_REQ(N), .M(8), .OP_W(4), .TIMEOUT(TO)) dut (
    .i_clk_p   (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_argA    (argA),
    .i_argB    (argB),
    .i_oper    (oper),
    .i_ack     (ack),
    .o_gnt     (o_gnt),
    .o_valid   (o_valid),
    .o_result  (o_result),
    .o_flags   (o_flags),
    .o_busy    (o_busy),
    .o_timeout (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sg(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // {BF,NF,OF,SF, result}
  function automatic logic [11:0] alu_model(input int a, input int b,
                                             input int op);
    int r, sv;
    bit bf, of;
    r = a; bf = 0; of = 0; sv = 0;
    case (op)
      0: begin
        r  = (a + b) % 256;
        bf = (a + b) > 255;
        sv = sg(a) + sg(b);
        of = (sv > 127) || (sv < -128);
      end
      1: begin
        r  = (a - b + 256) % 256;
        bf = a < b;
        sv = sg(a) - sg(b);
        of = (sv > 127) || (sv < -128);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a * 2) % 256; bf = a >= 128; end
      6: begin r = a / 2; bf = (a % 2) == 1; end
      default: r = a;
    endcase
    return {bf, (r == 0), of, (r >= 128), 8'(r)};
  endfunction

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // transaction model: 0 idle, 1 granted, 2 waiting for ack
  int          m_phase = 0;
  int          m_win = 0;
  int          m_last = N - 1;
  int          m_wait = 0;
  int          ca = 0, cb = 0, cop = 0;
  logic [3:0]  e_gnt = '0, e_valid = '0, e_flags = '0;
  logic [7:0]  e_result = '0;
  logic        e_tmo = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_last <= N - 1; m_wait <= 0;
      e_gnt <= '0; e_valid <= '0; e_result <= '0;
      e_flags <= '0; e_tmo <= 1'b0;
    end else begin
      e_gnt <= '0;
      e_tmo <= 1'b0;
      if (m_phase == 0) begin
        if (pick(req, m_last) >= 0) begin
          m_win   <= pick(req, m_last);
          ca      <= int'(argA[pick(req, m_last)*8 +: 8]);
          cb      <= int'(argB[pick(req, m_last)*8 +: 8]);
          cop     <= int'(oper[pick(req, m_last)*4 +: 4]);
          e_gnt   <= 4'(1 << pick(req, m_last));
          m_phase <= 1;
        end
      end else if (m_phase == 1) begin
        {e_flags, e_result} <= alu_model(ca, cb, cop);
        e_valid <= 4'(1 << m_win);
        m_wait  <= 0;
        m_phase <= 2;
      end else begin
        if (ack[m_win] || m_wait == TO - 1) begin
          e_valid <= '0;
          e_tmo   <= !ack[m_win];
          m_last  <= m_win;
          m_phase <= 0;
        end else begin
          m_wait <= m_wait + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("gnt", o_gnt, e_gnt);
    check("valid", o_valid, e_valid);
    check("result", o_result, e_result);
    check("flags", o_flags, e_flags);
    check("busy", o_busy, m_phase != 0);
    check("timeout", o_timeout, e_tmo);
    check("gnt_onehot", $countones(o_gnt) <= 1, 1);
    check("valid_onehot", $countones(o_valid) <= 1, 1);
  end

  logic       rec = 1'b0;
  logic [3:0] gq[$];
  always @(negedge clk)
    if (rec && o_gnt != 0) gq.push_back(o_gnt);

  task automatic wait_gnt(input string nm, input logic [3:0] exp);
    int n = 0;
    while (o_gnt == 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(nm, o_gnt, exp);
  endtask

  function automatic logic [21:0] all_out();
    return {o_gnt, o_valid, o_result, o_flags, o_busy, o_timeout};
  endfunction

  initial begin
    int n;
    logic [3:0] exp_ord [5];
    exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    repeat (2) @(negedge clk);
    check("reset_out", all_out(), 0);
    rst = 1'b0;

    // single request, 5+3
    argA[7:0] = 8'h05; argB[7:0] = 8'h03; oper[3:0] = 4'd0;
    req = 4'b0001;
    @(negedge clk);
    check("t1_gnt", o_gnt, 4'b0001);
    check("t1_nvalid", o_valid, 0);
    req = '0;
    @(negedge clk);
    check("t1_valid", o_valid, 4'b0001);
    check("t1_result", o_result, 8'h08);
    check("t1_flags", o_flags, 4'h0);
    ack = 4'b0001;
    @(negedge clk);
    check("t1_drop", o_valid, 0);
    check("t1_idle", o_busy, 0);
    ack = '0;

    // fairness with all lanes requesting and acking at once
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 4'hF; ack = 4'hF; rec = 1'b1;
    repeat (14) @(negedge clk);
    rec = 1'b0; req = '0;
    repeat (4) @(negedge clk);
    ack = '0;
    check("t2_count", gq.size(), 5);
    for (int i = 0; i < 5; i++)
      check("t2_order", (i < gq.size()) ? gq[i] : 4'h0, exp_ord[i]);

    // operands and request change after capture
    argA[15:8] = 8'h10; argB[15:8] = 8'h07; oper[7:4] = 4'd1;
    req = 4'b0010;
    wait_gnt("t3_gnt", 4'b0010);
    argA[15:8] = 8'hFF; argB[15:8] = 8'hFF; oper[7:4] = 4'd2;
    req = '0;
    @(negedge clk);
    check("t3_valid", o_valid, 4'b0010);
    check("t3_result", o_result, 8'h09);
    check("t3_flags", o_flags, 4'h0);
    ack = 4'b0010;
    @(negedge clk);
    ack = '0;

    // no ack: abort after TIMEOUT cycles; 0x80+0x80
    argA[7:0] = 8'h80; argB[7:0] = 8'h80; oper[3:0] = 4'd0;
    req = 4'b0001;
    wait_gnt("t4_gnt", 4'b0001);
    req = '0;
    @(negedge clk);
    check("t4_result", o_result, 8'h00);
    check("t4_flags", o_flags, 4'hE);
    n = 0;
    while (o_valid != 0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("t4_valid_len", n, TO);
    check("t4_tmo", o_timeout, 1);
    @(negedge clk);
    check("t4_tmo_once", o_timeout, 0);
    check("t4_keep_result", o_result, 8'h00);
    req = 4'b0011;
    wait_gnt("t4_next", 4'b0010);
    req = '0;
    @(negedge clk);
    ack = 4'b0010;
    @(negedge clk);
    ack = '0;

    // ack lands on the expiry cycle
    argA[23:16] = 8'h5A; argB[23:16] = 8'h5A; oper[11:8] = 4'd4;
    req = 4'b0100;
    wait_gnt("t4b_gnt", 4'b0100);
    req = '0;
    @(negedge clk);
    repeat (TO - 1) @(negedge clk);
    check("t4b_still", o_valid, 4'b0100);
    ack = 4'b0100;
    @(negedge clk);
    check("t4b_drop", o_valid, 0);
    check("t4b_notmo", o_timeout, 0);
    check("t4b_flags", o_flags, 4'h4);
    ack = '0;

    // stray acks on other lanes; 0x7F+1
    argA[7:0] = 8'h7F; argB[7:0] = 8'h01; oper[3:0] = 4'd0;
    req = 4'b0001;
    wait_gnt("t5_gnt", 4'b0001);
    ack = 4'b1110; req = '0;
    @(negedge clk);
    check("t5_result", o_result, 8'h80);
    check("t5_flags", o_flags, 4'h3);
    repeat (3) begin
      @(negedge clk);
      check("t5_hold", o_valid, 4'b0001);
      check("t5_busy", o_busy, 1);
    end
    ack = 4'b0001;
    @(negedge clk);
    check("t5_drop", o_valid, 0);
    ack = '0;

    // reset during EXEC then during RESP
    req = 4'b0100;
    wait_gnt("t6_gnt", 4'b0100);
    rst = 1'b1; req = '0;
    @(negedge clk);
    check("t6_rst_exec", all_out(), 0);
    rst = 1'b0; req = 4'hF;
    wait_gnt("t6_first", 4'b0001);
    @(negedge clk);
    ack = 4'b0001;
    @(negedge clk);
    ack = '0;
    wait_gnt("t6_second", 4'b0010);
    @(negedge clk);
    check("t6_resp", o_valid, 4'b0010);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_resp", all_out(), 0);
    rst = 1'b0;
    wait_gnt("t6_after", 4'b0001);
    req = '0; ack = 4'hF;
    repeat (3) @(negedge clk);
    ack = '0;

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 299) == 0);
      argA = $urandom;
      argB = $urandom;
      oper = 16'($urandom);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      for (int k = 0; k < N; k++) ack[k] = ($urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    rst = 1'b0; req = '0; ack = '0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
